// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types: branch codes, sequencer states, default widths
package proc_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_ALT  = 2'b11
    } br_code_e;

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_EXEC   = 2'b01,
        S_HALTED = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory fetch bus (req/ack handshake)
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/event_counter.sv
// rtl/event_counter.sv - free-running wrap-around event counter with synchronous clear
module event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner: fetch, hold for execute, commit next PC
// Outputs come only from registers or state decode; no input-to-output path.
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                PC_INC   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    imem,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              branchf,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);
    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              flush_q, flush_d;
    logic              retire_en;
    logic              taken_en;

    // halt wins over branchf: a halting instruction never counts as taken
    assign retire_en = (state_q == S_EXEC) && exec_done;
    assign taken_en  = retire_en && !halt && branchf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        flush_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        state_d = S_HALTED;
                    end else if (branchf) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(PC_INC);
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state_q == S_FETCH);
        imem.imem_addr = pc_q;
        instr_valid    = (state_q == S_EXEC);
        halted         = (state_q == S_HALTED);
        instr          = instr_q;
        pc             = pc_q;
        flush          = flush_q;
    end

    event_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .en_i    (retire_en),
        .count_o (retired_cnt)
    );

    event_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .en_i    (taken_en),
        .count_o (taken_cnt)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table plus directed sequences for pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: default widths
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid, exec_done, branchf, halt, flush, halted;
    logic [31:0] br_target, pc;
    logic [15:0] retired_cnt, taken_cnt;
    pc_sequencer_if #(.ADDR_W(32), .DATA_W(32)) imem_a ();

    pc_sequencer dut (
        .clk(clk), .reset(reset), .imem(imem_a),
        .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .branchf(branchf), .br_target(br_target), .halt(halt),
        .pc(pc), .flush(flush), .halted(halted),
        .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
    );

    // wrap instance: 8-bit PC starting at the top, 4-bit counters
    logic        b_reset;
    logic [31:0] b_instr;
    logic        b_instr_valid, b_exec_done, b_branchf, b_halt, b_flush, b_halted;
    logic [7:0]  b_br_target, b_pc;
    logic [3:0]  b_retired_cnt, b_taken_cnt;
    pc_sequencer_if #(.ADDR_W(8), .DATA_W(32)) imem_b ();

    pc_sequencer #(.ADDR_W(8), .DATA_W(32), .PC_INC(1), .RESET_PC(8'hFF), .CNT_W(4)) dut_b (
        .clk(clk), .reset(b_reset), .imem(imem_b),
        .instr(b_instr), .instr_valid(b_instr_valid),
        .exec_done(b_exec_done), .branchf(b_branchf), .br_target(b_br_target), .halt(b_halt),
        .pc(b_pc), .flush(b_flush), .halted(b_halted),
        .retired_cnt(b_retired_cnt), .taken_cnt(b_taken_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        done;
        logic        br;
        logic [31:0] tgt;
        logic        hlt;
        logic        e_req;
        logic        e_valid;
        logic        e_halted;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [15:0] e_ret;
        logic [15:0] e_tk;
    } vec_t;

    function automatic vec_t mk(
        input logic ack, input logic [31:0] rdata, input logic done, input logic br,
        input logic [31:0] tgt, input logic hlt,
        input logic e_req, input logic e_valid, input logic e_halted, input logic e_flush,
        input logic [31:0] e_pc, input logic [31:0] e_instr,
        input logic [15:0] e_ret, input logic [15:0] e_tk);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.done = done; v.br = br; v.tgt = tgt; v.hlt = hlt;
        v.e_req = e_req; v.e_valid = e_valid; v.e_halted = e_halted; v.e_flush = e_flush;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_ret = e_ret; v.e_tk = e_tk;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        //                ack rdata    done br tgt    hlt  req val hlt fl pc     instr    ret tk
        vt.push_back(mk(1, 32'hA0, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h0,  32'hA0, 0, 0));
        vt.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0,   1, 0, 0, 0, 32'h1,  32'hA0, 1, 0));
        vt.push_back(mk(1, 32'hA1, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h1,  32'hA1, 1, 0));
        vt.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0,   1, 0, 0, 0, 32'h2,  32'hA1, 2, 0));
        vt.push_back(mk(1, 32'hA2, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h2,  32'hA2, 2, 0));
        vt.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0,   1, 0, 0, 0, 32'h3,  32'hA2, 3, 0));
        vt.push_back(mk(1, 32'hA3, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h3,  32'hA3, 3, 0));
        vt.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0,   1, 0, 0, 0, 32'h4,  32'hA3, 4, 0));
        vt.push_back(mk(1, 32'hA4, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h4,  32'hA4, 4, 0));
        vt.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0,   1, 0, 0, 0, 32'h5,  32'hA4, 5, 0));
        vt.push_back(mk(1, 32'hA5, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h5,  32'hA5, 5, 0));
        vt.push_back(mk(0, 32'h0,  0, 1, 32'h77, 1,   0, 1, 0, 0, 32'h5,  32'hA5, 5, 0));
        vt.push_back(mk(0, 32'h0,  1, 1, 32'h40, 0,   1, 0, 0, 1, 32'h40, 32'hA5, 6, 1));
        vt.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h40, 32'hA5, 6, 1));
        vt.push_back(mk(0, 32'h0,  1, 1, 32'h9,  0,   1, 0, 0, 0, 32'h40, 32'hA5, 6, 1));
        vt.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h40, 32'hA5, 6, 1));
        vt.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0,   1, 0, 0, 0, 32'h40, 32'hA5, 6, 1));
        vt.push_back(mk(1, 32'hB0, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h40, 32'hB0, 6, 1));
        vt.push_back(mk(0, 32'h0,  1, 1, 32'h7,  0,   1, 0, 0, 1, 32'h7,  32'hB0, 7, 2));
        vt.push_back(mk(1, 32'hC0, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h7,  32'hC0, 7, 2));
        vt.push_back(mk(1, 32'hDD, 0, 0, 32'h0,  0,   0, 1, 0, 0, 32'h7,  32'hC0, 7, 2));
        vt.push_back(mk(0, 32'h0,  1, 1, 32'h99, 1,   0, 0, 1, 0, 32'h7,  32'hC0, 8, 2));

        reset = 1'b1; exec_done = 1'b0; branchf = 1'b0; br_target = '0; halt = 1'b0;
        imem_a.imem_ack = 1'b0; imem_a.imem_rdata = '0;
        b_reset = 1'b1; b_exec_done = 1'b0; b_branchf = 1'b0; b_br_target = '0; b_halt = 1'b0;
        imem_b.imem_ack = 1'b0; imem_b.imem_rdata = 32'h1234;

        tick();
        chk("rst pc", pc, 0);
        chk("rst req", imem_a.imem_req, 1);
        chk("rst addr", imem_a.imem_addr, 0);
        chk("rst valid", instr_valid, 0);
        chk("rst instr", instr, 0);
        chk("rst flush", flush, 0);
        chk("rst ret", retired_cnt, 0);
        chk("rst taken", taken_cnt, 0);
        reset = 1'b0;

        foreach (vt[i]) begin
            imem_a.imem_ack   = vt[i].ack;
            imem_a.imem_rdata = vt[i].rdata;
            exec_done = vt[i].done;
            branchf   = vt[i].br;
            br_target = vt[i].tgt;
            halt      = vt[i].hlt;
            tick();
            chk($sformatf("v%0d req", i), imem_a.imem_req, vt[i].e_req);
            chk($sformatf("v%0d valid", i), instr_valid, vt[i].e_valid);
            chk($sformatf("v%0d halted", i), halted, vt[i].e_halted);
            chk($sformatf("v%0d flush", i), flush, vt[i].e_flush);
            chk($sformatf("v%0d pc", i), pc, vt[i].e_pc);
            chk($sformatf("v%0d addr", i), imem_a.imem_addr, vt[i].e_pc);
            chk($sformatf("v%0d instr", i), instr, vt[i].e_instr);
            chk($sformatf("v%0d ret", i), retired_cnt, vt[i].e_ret);
            chk($sformatf("v%0d taken", i), taken_cnt, vt[i].e_tk);
        end

        // halted is sticky; ack and exec_done are ignored
        imem_a.imem_ack = 1'b1; exec_done = 1'b1; branchf = 1'b1; halt = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hlt%0d req", c), imem_a.imem_req, 0);
            chk($sformatf("hlt%0d halted", c), halted, 1);
            chk($sformatf("hlt%0d pc", c), pc, 32'h7);
            chk($sformatf("hlt%0d ret", c), retired_cnt, 8);
        end

        // leave HALTED through reset, then reset mid-EXEC with a taken branch pending
        reset = 1'b1; imem_a.imem_ack = 1'b0; exec_done = 1'b0; branchf = 1'b0;
        tick();
        chk("rh halted", halted, 0);
        chk("rh req", imem_a.imem_req, 1);
        reset = 1'b0; imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'hE0;
        tick();
        chk("re valid", instr_valid, 1);
        chk("re instr", instr, 32'hE0);
        reset = 1'b1; imem_a.imem_ack = 1'b0;
        exec_done = 1'b1; branchf = 1'b1; br_target = 32'h55;
        tick();
        chk("rx pc", pc, 0);
        chk("rx flush", flush, 0);
        chk("rx ret", retired_cnt, 0);
        chk("rx taken", taken_cnt, 0);
        chk("rx req", imem_a.imem_req, 1);
        chk("rx addr", imem_a.imem_addr, 0);
        chk("rx valid", instr_valid, 0);
        exec_done = 1'b0; branchf = 1'b0;

        // reset wins over an ack in the same edge
        imem_a.imem_ack = 1'b1; imem_a.imem_rdata = 32'hF0;
        tick();
        chk("ra valid", instr_valid, 0);
        chk("ra instr", instr, 0);
        reset = 1'b0; imem_a.imem_ack = 1'b0;
        tick();
        chk("ra2 req", imem_a.imem_req, 1);
        chk("ra2 valid", instr_valid, 0);

        // PC and counter wrap on the narrow instance
        tick();
        chk("b rst pc", b_pc, 8'hFF);
        chk("b rst req", imem_b.imem_req, 1);
        b_reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            logic [7:0] ep;
            logic [3:0] er;
            ep = 8'hFF + 8'(k);
            er = 4'(k);
            imem_b.imem_ack = 1'b1;
            tick();
            imem_b.imem_ack = 1'b0; b_exec_done = 1'b1;
            tick();
            b_exec_done = 1'b0;
            chk($sformatf("b%0d pc", k), b_pc, ep);
            chk($sformatf("b%0d ret", k), b_retired_cnt, er);
            chk($sformatf("b%0d taken", k), b_taken_cnt, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
